// File: rtl/calc3_port_tagger.sv
// calc3_port_tagger: per-port request agent that tags host commands for calc3_top and returns tagged completions.
//   Ports: c_clk/reset; host_valid/host_ready/host_cmd/host_d1/host_d2/host_r1/host_data (command in);
//          req_cmd/req_d1/req_d2/req_r1/req_data/req_tag (one-cycle pulse to calc3_top);
//          out_resp/out_tag/out_data (response from calc3_top);
//          cpl_valid/cpl_ready/cpl_tag/cpl_resp/cpl_data (completion buffer head);
//          outstanding (allocated tags), stray_resp (dropped response pulse).
//   Optional feature: define TAGGER_TIMEOUT_EN for per-tag timeout completions with response code 11.
module calc3_port_tagger #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int CNT_W           = 7
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [0:3]  host_cmd,
   input  logic [0:3]  host_d1,
   input  logic [0:3]  host_d2,
   input  logic [0:3]  host_r1,
   input  logic [0:31] host_data,
   output logic [0:3]  req_cmd,
   output logic [0:3]  req_d1,
   output logic [0:3]  req_d2,
   output logic [0:3]  req_r1,
   output logic [0:31] req_data,
   output logic [0:1]  req_tag,
   input  logic [0:1]  out_resp,
   input  logic [0:1]  out_tag,
   input  logic [0:31] out_data,
   output logic        cpl_valid,
   input  logic        cpl_ready,
   output logic [0:1]  cpl_tag,
   output logic [0:1]  cpl_resp,
   output logic [0:31] cpl_data,
   output logic [0:2]  outstanding,
   output logic        stray_resp
);
   typedef enum logic [1:0] {FREE, ISSUED, DONE} tag_st_t;
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4 || TIMEOUT_CYCLES < 2 || CNT_W < $clog2(TIMEOUT_CYCLES + 1))
      $error("calc3_port_tagger: illegal parameters");
   tag_st_t     st [4];
   logic [0:1]  b_tag [4];
   logic [0:1]  b_resp [4];
   logic [0:31] b_data [4];
   logic [1:0]  wr, rd;
   logic [2:0]  fill;
   logic        has_free, alloc, resp_hit, push, pop, to_hit;
   logic [0:1]  free_tag, to_tag, push_tag, push_resp;
   logic [0:31] push_data;
   // Downward scan so the lowest free tag wins; tags at or above MAX_OUTSTANDING are never candidates.
   always_comb begin
      has_free = 1'b0;
      free_tag = 2'd0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
         if (st[i] == FREE) begin
            has_free = 1'b1;
            free_tag = 2'(i);
         end
   end
   always_comb begin
      outstanding = 3'd0;
      for (int i = 0; i < 4; i++) outstanding = outstanding + {2'b00, st[i] != FREE};
   end
`ifdef TAGGER_TIMEOUT_EN
   logic [CNT_W-1:0] cnt [4];
   always_comb begin
      to_hit = 1'b0;
      to_tag = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (st[i] == ISSUED && cnt[i] == CNT_W'(TIMEOUT_CYCLES)) begin
            to_hit = 1'b1;
            to_tag = 2'(i);
         end
   end
   // Counter reads 1 during the req pulse cycle, so a saturated tag is pushed TIMEOUT_CYCLES after the pulse.
   always_ff @(posedge c_clk)
      for (int i = 0; i < 4; i++)
         if (reset) cnt[i] <= '0;
         else if (alloc && free_tag == 2'(i)) cnt[i] <= CNT_W'(1);
         else if (st[i] == ISSUED && cnt[i] != CNT_W'(TIMEOUT_CYCLES)) cnt[i] <= cnt[i] + CNT_W'(1);
`else
   assign to_hit = 1'b0;
   assign to_tag = 2'd0;
`endif
   assign host_ready = !reset && has_free;
   assign alloc      = host_valid && host_ready && host_cmd != 4'd0;
   // Unallocated tags (including those >= MAX_OUTSTANDING) always read FREE, so one state test covers them.
   assign resp_hit   = out_resp != 2'b00 && st[out_tag] == ISSUED;
   assign push       = resp_hit || to_hit;
   assign push_tag   = resp_hit ? out_tag : to_tag;
   assign push_resp  = resp_hit ? out_resp : 2'b11;
   assign push_data  = resp_hit ? out_data : 32'd0;
   assign cpl_valid  = fill != 3'd0;
   assign pop        = cpl_valid && cpl_ready;
   assign cpl_tag    = cpl_valid ? b_tag[rd] : 2'd0;
   assign cpl_resp   = cpl_valid ? b_resp[rd] : 2'd0;
   assign cpl_data   = cpl_valid ? b_data[rd] : 32'd0;
   always_ff @(posedge c_clk)
      if (push) begin
         b_tag[wr]  <= push_tag;
         b_resp[wr] <= push_resp;
         b_data[wr] <= push_data;
      end
   always_ff @(posedge c_clk)
      if (reset) begin
         for (int i = 0; i < 4; i++) st[i] <= FREE;
         {req_cmd, req_d1, req_d2, req_r1, req_data, req_tag} <= '0;
         stray_resp <= 1'b0;
         wr <= 2'd0;
         rd <= 2'd0;
         fill <= 3'd0;
      end else begin
         req_cmd <= alloc ? host_cmd : 4'd0;
         req_d1 <= alloc ? host_d1 : 4'd0;
         req_d2 <= alloc ? host_d2 : 4'd0;
         req_r1 <= alloc ? host_r1 : 4'd0;
         req_data <= alloc ? host_data : 32'd0;
         req_tag <= alloc ? free_tag : 2'd0;
         stray_resp <= out_resp != 2'b00 && !resp_hit;
         if (alloc) st[free_tag] <= ISSUED;
         if (push) st[push_tag] <= DONE;
         if (pop) st[b_tag[rd]] <= FREE;
         wr <= wr + 2'(push);
         rd <= rd + 2'(pop);
         fill <= fill + 3'(push) - 3'(pop);
      end
endmodule

// File: tb/tb_calc3_port_tagger.sv
// tb_calc3_port_tagger: directed vector table, timeout sequence and randomized model check of calc3_port_tagger.
module tb_calc3_port_tagger;
   localparam int MAXO = 4;
   localparam int TO   = 8;
`ifdef TAGGER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic c_clk = 1'b0;
   logic reset, host_valid, host_ready, cpl_valid, cpl_ready, stray_resp;
   logic [0:3] host_cmd, host_d1, host_d2, host_r1, req_cmd, req_d1, req_d2, req_r1;
   logic [0:31] host_data, req_data, out_data, cpl_data;
   logic [0:1] req_tag, out_resp, out_tag, cpl_tag, cpl_resp;
   logic [0:2] outstanding;
   int n_vec = 0, n_err = 0;
   always #5 c_clk = ~c_clk;
   calc3_port_tagger #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
      .c_clk(c_clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
      .host_cmd(host_cmd), .host_d1(host_d1), .host_d2(host_d2), .host_r1(host_r1), .host_data(host_data),
      .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1), .req_data(req_data), .req_tag(req_tag),
      .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
      .outstanding(outstanding), .stray_resp(stray_resp));
   typedef struct {
      bit rst, hv, crdy;
      logic [3:0] cmd;
      logic [1:0] oresp, otag;
      logic [31:0] odata;
      bit rdy, cv, stray;
      logic [3:0] rcmd;
      logic [1:0] rtag, ct, cr;
      logic [31:0] cd;
      int outs;
   } vec_t;
   typedef struct {
      logic [1:0] tag, resp;
      logic [31:0] data;
   } cpl_t;
   vec_t tbl[$];
   bit busy[4], iss[4];
   longint dl[4];
   longint ecnt = 0;
   cpl_t q[$];
   logic [49:0] e_req = '0;
   bit e_stray = 1'b0;
   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask
   function automatic vec_t mk(bit rst, bit hv, logic [3:0] cmd, bit crdy, logic [1:0] oresp, logic [1:0] otag,
                               logic [31:0] odata, bit rdy, logic [3:0] rcmd, logic [1:0] rtag, bit cv,
                               logic [1:0] ct, logic [1:0] cr, logic [31:0] cd, int outs, bit stray);
      vec_t v;
      v.rst = rst; v.hv = hv; v.cmd = cmd; v.crdy = crdy; v.oresp = oresp; v.otag = otag; v.odata = odata;
      v.rdy = rdy; v.rcmd = rcmd; v.rtag = rtag; v.cv = cv; v.ct = ct; v.cr = cr; v.cd = cd; v.outs = outs;
      v.stray = stray;
      return v;
   endfunction
   // Reference model: tag sets, arrival-ordered completion queue and absolute timeout deadlines.
   function automatic void model_edge();
      int t;
      bit acc, rp, pop;
      cpl_t c;
      ecnt++;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin busy[i] = 0; iss[i] = 0; end
         q.delete();
         e_req = '0;
         e_stray = 0;
         return;
      end
      t = -1;
      for (int i = MAXO - 1; i >= 0; i--) if (!busy[i]) t = i;
      acc = host_valid && t >= 0;
      pop = q.size() > 0 && cpl_ready;
      rp = out_resp != 2'b00 && iss[out_tag];
      e_stray = out_resp != 2'b00 && !rp;
      if (pop) begin
         c = q.pop_front();
         busy[c.tag] = 0;
      end
      if (rp) begin
         iss[out_tag] = 0;
         c.tag = out_tag; c.resp = out_resp; c.data = out_data;
         q.push_back(c);
      end else if (TO_EN)
         for (int i = 0; i < 4; i++)
            if (iss[i] && ecnt >= dl[i]) begin
               iss[i] = 0;
               c.tag = 2'(i); c.resp = 2'b11; c.data = 32'd0;
               q.push_back(c);
               break;
            end
      e_req = '0;
      if (acc && host_cmd != 4'd0) begin
         busy[t] = 1;
         iss[t] = 1;
         dl[t] = ecnt + TO;
         e_req = {host_cmd, host_d1, host_d2, host_r1, host_data, 2'(t)};
      end
   endfunction
   task automatic check_all(string p);
      int o = 0;
      foreach (busy[i]) o += int'(busy[i]);
      chk({p, " host_ready"}, host_ready, !reset && o < MAXO);
      chk({p, " req"}, {req_cmd, req_d1, req_d2, req_r1, req_data, req_tag}, e_req);
      chk({p, " cpl"}, {cpl_valid, cpl_tag, cpl_resp, cpl_data},
          q.size() > 0 ? {1'b1, q[0].tag, q[0].resp, q[0].data} : 37'd0);
      chk({p, " outstanding"}, outstanding, o);
      chk({p, " stray"}, stray_resp, e_stray);
   endtask
   task automatic tick(string p);
      model_edge();
      @(posedge c_clk);
      #2;
      check_all(p);
   endtask
   initial begin
      reset = 1; host_valid = 0; host_cmd = 0; host_d1 = 2; host_d2 = 3; host_r1 = 4; host_data = 0;
      cpl_ready = 0; out_resp = 0; out_tag = 0; out_data = 0;
      //               rst hv cmd crdy oresp otag odata  rdy rcmd rtag cv ct cr cd    outs stray
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,        1, 1, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5,        1, 0, 0, 1, 0, 1, 5,     1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 3, 9,        1, 0, 0, 0, 0, 0, 0,     0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0,        1, 2, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0,        1, 3, 1, 0, 0, 0, 0,     2, 0));
      tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0,        1, 4, 2, 0, 0, 0, 0,     3, 0));
      tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0,        0, 5, 3, 0, 0, 0, 0,     4, 0));
      tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0,     4, 0));
      tbl.push_back(mk(0, 1, 6, 0, 1, 2, 'h22,     0, 0, 0, 1, 2, 1, 'h22,  4, 0));
      tbl.push_back(mk(0, 1, 6, 0, 2, 0, 'h33,     0, 0, 0, 1, 2, 1, 'h22,  4, 0));
      tbl.push_back(mk(0, 1, 6, 1, 0, 0, 0,        1, 0, 0, 1, 0, 2, 'h33,  3, 0));
      tbl.push_back(mk(0, 1, 6, 0, 0, 0, 0,        0, 6, 2, 1, 0, 2, 'h33,  4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     3, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7,        1, 0, 0, 1, 1, 1, 7,     3, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,        0, 1, 0, 1, 1, 1, 7,     4, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1,        0, 0, 0, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0,        1, 9, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 2, 4,        1, 0, 0, 0, 0, 0, 0,     1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0,     1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0,     0, 0));
`ifndef TAGGER_TIMEOUT_EN
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; host_valid = tbl[i].hv; host_cmd = tbl[i].cmd; cpl_ready = tbl[i].crdy;
         out_resp = tbl[i].oresp; out_tag = tbl[i].otag; out_data = tbl[i].odata;
         @(posedge c_clk);
         #2;
         chk($sformatf("row%0d host_ready", i), host_ready, tbl[i].rdy);
         chk($sformatf("row%0d req", i), {req_cmd, req_tag}, {tbl[i].rcmd, tbl[i].rtag});
         chk($sformatf("row%0d cpl", i), {cpl_valid, cpl_tag, cpl_resp, cpl_data},
             {tbl[i].cv, tbl[i].ct, tbl[i].cr, tbl[i].cd});
         chk($sformatf("row%0d outstanding", i), outstanding, tbl[i].outs);
         chk($sformatf("row%0d stray", i), stray_resp, tbl[i].stray);
      end
`endif
      reset = 1; host_valid = 0; cpl_ready = 0; out_resp = 0;
      tick("rst");
      reset = 0;
`ifdef TAGGER_TIMEOUT_EN
      host_valid = 1; host_cmd = 1;
      tick("t5 accept");
      host_valid = 0;
      for (int j = 1; j <= TO; j++) begin
         tick("t5 wait");
         chk($sformatf("t5 cpl_valid@%0d", j), cpl_valid, j == TO);
      end
      chk("t5 cpl", {cpl_tag, cpl_resp, cpl_data}, {2'd0, 2'b11, 32'd0});
      out_resp = 2'b01; out_tag = 0; out_data = 32'h77;
      tick("t5 late");
      chk("t5 stray", stray_resp, 1'b1);
      out_resp = 0; cpl_ready = 1;
      tick("t5 pop");
`endif
      for (int k = 0; k < 1500; k++) begin
         reset = $urandom_range(199) == 0;
         host_valid = $urandom_range(1);
         host_cmd = $urandom_range(3) == 0 ? 4'd0 : 4'($urandom);
         host_d1 = 4'($urandom); host_d2 = 4'($urandom); host_r1 = 4'($urandom); host_data = $urandom;
         cpl_ready = $urandom_range(2) == 0;
         out_resp = $urandom_range(2) == 0 ? 2'($urandom_range(3, 1)) : 2'b00;
         out_tag = 2'($urandom);
         out_data = $urandom;
         tick($sformatf("rnd%0d", k));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
